// File: rtl/microseq_unit.sv
// Programmable microsequencer for the multicycle MIPS datapath.
// Contains a writable control store and a writable dispatch CAM that is shared
// by three dispatch tables. It adds stall, wait-on-condition, an overflow
// exception vector and an invalid-opcode vector. The control word is read
// combinationally from the store at the current micro-address.
module microseq_unit #(
    parameter int CW_WIDTH    = 36,
    parameter int ADDR_WIDTH  = 5,
    parameter int OPC_WIDTH   = 6,
    parameter int FUNCT_WIDTH = 6,
    parameter int DT_ENTRIES  = 32,
    parameter int EXC_VEC     = 30,
    parameter int INV_VEC     = 31
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [OPC_WIDTH-1:0]                         opcode,
    input  logic [FUNCT_WIDTH-1:0]                       funct,
    input  logic                                         of,
    input  logic                                         stall,
    input  logic                                         wait_cond,
    input  logic                                         cs_we,
    input  logic [ADDR_WIDTH-1:0]                        cs_waddr,
    input  logic [CW_WIDTH-1:0]                          cs_wdata,
    input  logic                                         dt_we,
    input  logic [$clog2(DT_ENTRIES)-1:0]                dt_waddr,
    input  logic [4+OPC_WIDTH+FUNCT_WIDTH+ADDR_WIDTH-1:0] dt_wdata,
    output logic [CW_WIDTH-1:0]                          cw,
    output logic [ADDR_WIDTH-1:0]                        current_state,
    output logic                                         exc_taken,
    output logic                                         invalid_op
);

    localparam int CS_DEPTH = 2 ** ADDR_WIDTH;

    // Sequencing-field encodings (ACTRL = cw[2:0]).
    localparam logic [2:0] A_FETCH = 3'b000;
    localparam logic [2:0] A_SEQ   = 3'b001;
    localparam logic [2:0] A_DISP1 = 3'b010;
    localparam logic [2:0] A_DISP2 = 3'b011;
    localparam logic [2:0] A_DISP3 = 3'b100;
    localparam logic [2:0] A_WAIT  = 3'b101;
    localparam logic [2:0] A_TRAP  = 3'b110;
    localparam logic [2:0] A_INV   = 3'b111;

    localparam logic [ADDR_WIDTH-1:0] EXC_ADDR = ADDR_WIDTH'(EXC_VEC);
    localparam logic [ADDR_WIDTH-1:0] INV_ADDR = ADDR_WIDTH'(INV_VEC);

    // Bit positions of {valid, tbl[1:0], fmask, opcode, funct, target} in dt_wdata.
    localparam int F_LSB  = ADDR_WIDTH;
    localparam int O_LSB  = F_LSB + FUNCT_WIDTH;
    localparam int M_BIT  = O_LSB + OPC_WIDTH;
    localparam int TB_LSB = M_BIT + 1;
    localparam int V_BIT  = TB_LSB + 2;

    logic [CW_WIDTH-1:0]    cs [CS_DEPTH];
    logic [ADDR_WIDTH-1:0]  upc;

    logic [DT_ENTRIES-1:0]  dt_valid;
    logic [1:0]             dt_tbl    [DT_ENTRIES];
    logic                   dt_fmask  [DT_ENTRIES];
    logic [OPC_WIDTH-1:0]   dt_opc    [DT_ENTRIES];
    logic [FUNCT_WIDTH-1:0] dt_funct  [DT_ENTRIES];
    logic [ADDR_WIDTH-1:0]  dt_target [DT_ENTRIES];

    logic [2:0]             actrl;
    logic [1:0]             sel_tbl;
    logic                   hit;
    logic [ADDR_WIDTH-1:0]  hit_target;
    logic [ADDR_WIDTH-1:0]  upc_next;
    logic                   exc_next;
    logic                   inv_next;

    assign cw            = cs[upc];
    assign current_state = upc;
    assign actrl         = cw[2:0];

    // Map the dispatch ACTRL codes onto table numbers 1..3; 0 means no dispatch.
    always_comb begin
        sel_tbl = 2'd0;
        case (actrl)
            A_DISP1: sel_tbl = 2'd1;
            A_DISP2: sel_tbl = 2'd2;
            A_DISP3: sel_tbl = 2'd3;
            default: sel_tbl = 2'd0;
        endcase
    end

    // CAM search: the lowest-index matching entry wins; tbl=0 entries never match.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        hit        = 1'b0;
        hit_target = '0;
        for (int i = 0; i < DT_ENTRIES; i++) begin
            if (!hit && dt_valid[i] && (sel_tbl != 2'd0) && (dt_tbl[i] == sel_tbl) &&
                (dt_opc[i] == opcode) && (!dt_fmask[i] || (dt_funct[i] == funct))) begin
                hit        = 1'b1;
                hit_target = dt_target[i];
            end
        end
    end

    // Next micro-address and pulse decode: stall, then overflow, then ACTRL.
    always_comb begin
        upc_next = upc;
        exc_next = 1'b0;
        inv_next = 1'b0;
        if (stall) begin
            upc_next = upc;
        end else if (of) begin
            upc_next = EXC_ADDR;
            exc_next = 1'b1;
        end else begin
            case (actrl)
                A_FETCH: upc_next = '0;
                A_SEQ:   upc_next = upc + ADDR_WIDTH'(1);
                A_DISP1, A_DISP2, A_DISP3: begin
                    if (hit) begin
                        upc_next = hit_target;
                    end else begin
                        upc_next = INV_ADDR;
                        inv_next = 1'b1;
                    end
                end
                A_WAIT:  upc_next = wait_cond ? upc : upc + ADDR_WIDTH'(1);
                A_TRAP: begin
                    upc_next = EXC_ADDR;
                    exc_next = 1'b1;
                end
                A_INV: begin
                    upc_next = INV_ADDR;
                    inv_next = 1'b1;
                end
                default: upc_next = '0;
            endcase
        end
    end

    // Sequencer state and CAM valid bits; reset clears them and overrides any write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            upc        <= '0;
            exc_taken  <= 1'b0;
            invalid_op <= 1'b0;
            dt_valid   <= '0;
        end else begin
            upc        <= upc_next;
            exc_taken  <= exc_next;
            invalid_op <= inv_next;
            if (dt_we) begin
                dt_valid[dt_waddr] <= dt_wdata[V_BIT];
            end
        end
    end

    // Control store write; contents survive reset, and writes are ignored while reset is high.
    always_ff @(posedge clk) begin
        // NOTE: memory arrays carry no reset; only the valid bits above gate their use.
        if (cs_we && !reset) begin
            cs[cs_waddr] <= cs_wdata;
        end
    end

    // CAM payload write; harmless during reset because the entry stays invalid.
    always_ff @(posedge clk) begin
        if (dt_we) begin
            dt_tbl[dt_waddr]    <= dt_wdata[TB_LSB +: 2];
            dt_fmask[dt_waddr]  <= dt_wdata[M_BIT];
            dt_opc[dt_waddr]    <= dt_wdata[O_LSB +: OPC_WIDTH];
            dt_funct[dt_waddr]  <= dt_wdata[F_LSB +: FUNCT_WIDTH];
            dt_target[dt_waddr] <= dt_wdata[ADDR_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_microseq_unit.sv
// Self-checking bench for microseq_unit. A behavioural model follows the
// sequencing rules directly and is compared with the DUT every cycle. Literal
// expectations at key points pin the model itself.
module tb_microseq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        of;
    logic        stall;
    logic        wait_cond;
    logic        cs_we;
    logic [4:0]  cs_waddr;
    logic [35:0] cs_wdata;
    logic        dt_we;
    logic [4:0]  dt_waddr;
    logic [20:0] dt_wdata;
    logic [35:0] cw;
    logic [4:0]  current_state;
    logic        exc_taken;
    logic        invalid_op;

    microseq_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .of(of),
        .stall(stall), .wait_cond(wait_cond), .cs_we(cs_we), .cs_waddr(cs_waddr),
        .cs_wdata(cs_wdata), .dt_we(dt_we), .dt_waddr(dt_waddr), .dt_wdata(dt_wdata),
        .cw(cw), .current_state(current_state), .exc_taken(exc_taken),
        .invalid_op(invalid_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int tbl;
        bit fm;
        int opc;
        int fn;
        int tgt;
    } cam_t;

    logic [35:0] m_cs [32];
    cam_t        m_cam [32];
    int          m_upc = 0;
    bit          m_exc = 1'b0;
    bit          m_inv = 1'b0;
    bit          chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] mkcw(input logic [2:0] a, input int tag);
        return {33'(tag), a};
    endfunction

    // Microprogram: tag = address + 100 in the upper bits, ACTRL in the low three bits.
    function automatic logic [2:0] prog_actrl(input int a);
        case (a)
            0, 2, 3, 4, 12, 13, 31: return 3'b001;
            1:  return 3'b010;
            5:  return 3'b101;
            6:  return 3'b110;
            8:  return 3'b111;
            9:  return 3'b011;
            10: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int lookup(input int t);
        for (int i = 0; i < 32; i++) begin
            if (m_cam[i].v && m_cam[i].tbl == t && m_cam[i].opc == int'(opcode) &&
                (!m_cam[i].fm || m_cam[i].fn == int'(funct)))
                return m_cam[i].tgt;
        end
        return -1;
    endfunction

    // Advance one clock: the model decides from pre-edge state and inputs, then commits after the edge.
    task automatic tick();
        int   nu;
        bit   ne;
        bit   ni;
        int   a;
        int   hitv;
        bit   rst;
        bit   do_cs;
        int   csa;
        logic [35:0] csd;
        bit   do_dt;
        int   di;
        int   w;
        cam_t de;
        nu = m_upc; ne = 0; ni = 0; rst = reset; do_cs = 0; do_dt = 0;
        csa = 0; csd = '0; di = 0; de = '{0, 0, 0, 0, 0, 0};
        if (!rst) begin
            if (!stall) begin
                if (of) begin
                    nu = 30; ne = 1;
                end else begin
                    a = int'(m_cs[m_upc] % 8);
                    case (a)
                        0: nu = 0;
                        1: nu = (m_upc + 1) % 32;
                        2, 3, 4: begin
                            hitv = lookup(a - 1);
                            if (hitv < 0) begin nu = 31; ni = 1; end
                            else nu = hitv;
                        end
                        5: nu = wait_cond ? m_upc : (m_upc + 1) % 32;
                        6: begin nu = 30; ne = 1; end
                        default: begin nu = 31; ni = 1; end
                    endcase
                end
            end
            if (cs_we) begin do_cs = 1; csa = int'(cs_waddr); csd = cs_wdata; end
            if (dt_we) begin
                do_dt = 1;
                di = int'(dt_waddr);
                w = int'(dt_wdata);
                de.tgt = w % 32;
                de.fn  = (w / 32) % 64;
                de.opc = (w / 2048) % 64;
                de.fm  = bit'((w / 131072) % 2);
                de.tbl = (w / 262144) % 4;
                de.v   = bit'((w / 1048576) % 2);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_upc = 0; m_exc = 0; m_inv = 0;
            for (int i = 0; i < 32; i++) m_cam[i].v = 0;
        end else begin
            m_upc = nu; m_exc = ne; m_inv = ni;
            if (do_cs) m_cs[csa] = csd;
            if (do_dt) m_cam[di] = de;
        end
        #1;
    endtask

    task automatic dt_write(input int idx, input logic v, input logic [1:0] tbl, input logic fm,
                            input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] tgt);
        dt_we    = 1'b1;
        dt_waddr = 5'(idx);
        dt_wdata = {v, tbl, fm, opc, fn, tgt};
        tick();
        dt_we    = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Compare process: DUT against model on every falling edge once the store is known.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cw", cw, m_cs[m_upc]);
            check("upc", current_state, 64'(m_upc));
            check("exc_taken", exc_taken, 64'(m_exc));
            check("invalid_op", invalid_op, 64'(m_inv));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) m_cam[i] = '{0, 0, 0, 0, 0, 0};
        reset = 1'b1; opcode = '0; funct = '0; of = 1'b0; stall = 1'b0; wait_cond = 1'b0;
        cs_we = 1'b0; cs_waddr = '0; cs_wdata = '0; dt_we = 1'b0; dt_waddr = '0; dt_wdata = '0;
        ticks(2);
        check("reset_upc", current_state, 0);
        check("reset_pulses", {exc_taken, invalid_op}, 0);

        // Load the microprogram while the sequencer is frozen at address 0.
        reset = 1'b0; stall = 1'b1;
        for (int a = 0; a < 32; a++) begin
            cs_we = 1'b1; cs_waddr = 5'(a); cs_wdata = mkcw(prog_actrl(a), a + 100);
            tick();
        end
        cs_we = 1'b0;
        chk_en = 1'b1;
        check("boot_upc", current_state, 0);
        check("boot_cw", cw, 801);

        dt_write(0, 1, 1, 0, 0, 0, 12);
        dt_write(1, 1, 1, 1, 0, 32, 13);
        dt_write(2, 1, 1, 0, 4, 0, 2);
        dt_write(3, 1, 0, 0, 9, 0, 20);
        dt_write(4, 1, 1, 0, 9, 0, 9);
        dt_write(5, 1, 2, 0, 9, 0, 10);
        dt_write(6, 1, 3, 0, 9, 0, 8);

        // Boot: SEQ then dispatch; CAM[0] must win over CAM[1].
        opcode = 6'd0; funct = 6'd32; stall = 1'b0;
        tick(); check("seq_to_1", current_state, 1);
        tick(); check("disp_lowest_wins", current_state, 12);
        check("cw_at_12", cw, 897);
        ticks(3); check("fetch_to_0", current_state, 0);

        // Funct-qualified dispatch once CAM[0] is invalid.
        stall = 1'b1; dt_write(0, 0, 1, 0, 0, 0, 12); stall = 1'b0;
        ticks(2); check("funct_disp", current_state, 13);
        ticks(2);
        funct = 6'd24;
        ticks(2); check("miss_upc", current_state, 31);
        check("miss_pulse", invalid_op, 1);
        tick(); check("wrap_to_0", current_state, 0);
        check("miss_pulse_clear", invalid_op, 0);

        // Overflow, with and without stall.
        stall = 1'b1; dt_write(0, 1, 1, 0, 0, 0, 12); stall = 1'b0; funct = 6'd32;
        ticks(2); check("back_at_12", current_state, 12);
        of = 1'b1; tick(); of = 1'b0;
        check("of_upc", current_state, 30);
        check("of_pulse", exc_taken, 1);
        tick(); check("of_pulse_clear", exc_taken, 0);
        ticks(2);
        stall = 1'b1; of = 1'b1; tick(); stall = 1'b0; of = 1'b0;
        check("of_stalled_upc", current_state, 12);
        check("of_stalled_pulse", exc_taken, 0);
        tick(); check("after_stall_13", current_state, 13);
        ticks(3);
        of = 1'b1; tick(); of = 1'b0;
        check("of_over_dispatch", current_state, 30);
        tick();

        // Stall during SEQ, then WAIT on wait_cond, then TRAP.
        opcode = 6'd4;
        ticks(2); check("disp_to_2", current_state, 2);
        stall = 1'b1; ticks(2); stall = 1'b0;
        check("stall_hold", current_state, 2);
        ticks(3); check("at_wait", current_state, 5);
        wait_cond = 1'b1; ticks(2);
        check("wait_hold", current_state, 5);
        wait_cond = 1'b0; tick(); check("wait_release", current_state, 6);
        tick(); check("trap_upc", current_state, 30);
        check("trap_pulse", exc_taken, 1);
        tick();

        // Dispatch through tables 1, 2, 3; the tbl=0 entry at index 3 must be skipped.
        opcode = 6'd9;
        ticks(2); check("tbl1_skip_tbl0", current_state, 9);
        tick(); check("tbl2", current_state, 10);
        tick(); check("tbl3", current_state, 8);
        tick(); check("invalid_actrl", current_state, 31);
        check("invalid_actrl_pulse", invalid_op, 1);
        tick();

        // Live write of the executing word: the decode uses the old WAIT, and cw changes one cycle later.
        opcode = 6'd4;
        ticks(5);
        wait_cond = 1'b1;
        check("live_cw_old", cw, 845);
        cs_we = 1'b1; cs_waddr = 5'd5; cs_wdata = mkcw(3'b001, 999);
        tick(); cs_we = 1'b0;
        check("live_old_decode", current_state, 5);
        check("live_cw_new", cw, 7993);
        wait_cond = 1'b0; tick(); check("live_seq", current_state, 6);
        ticks(2);

        // Reset in a dispatch state with stall, overflow and a CAM write all pending.
        opcode = 6'd0; funct = 6'd32;
        tick(); check("pre_reset_disp", current_state, 1);
        reset = 1'b1; stall = 1'b1; of = 1'b1;
        dt_we = 1'b1; dt_waddr = 5'd7; dt_wdata = {1'b1, 2'd1, 1'b0, 6'd0, 6'd0, 5'd12};
        tick();
        reset = 1'b0; stall = 1'b0; of = 1'b0; dt_we = 1'b0;
        check("rst_upc", current_state, 0);
        check("rst_pulses", {exc_taken, invalid_op}, 0);
        check("rst_cs_kept", cw, 801);
        ticks(2); check("rst_cam_cleared", current_state, 31);
        check("rst_cam_pulse", invalid_op, 1);
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/microseq_unit.md
Name: microseq_unit

Overview:
- Parametrised, programmable microsequencer for the multicycle MIPS datapath; next generation of the fixed-ROM microprogrammed control unit.
- Holds a writable control store and a writable dispatch CAM, so microcode and decode tables load at run time instead of being hard-coded.
- Adds run-time stall, wait-on-condition, and dedicated overflow-exception and invalid-opcode vectors.
- Drives the control word to the datapath every cycle.

Parameters:
- CW_WIDTH, 36, control word width; bits [2:0] are the sequencing field ACTRL.
- ADDR_WIDTH, 5, micro-address width; control store depth is 2**ADDR_WIDTH.
- OPC_WIDTH, 6, opcode width.
- FUNCT_WIDTH, 6, funct width.
- DT_ENTRIES, 32, dispatch CAM entries shared by 3 dispatch tables.
- EXC_VEC, 30, micro-address taken on overflow.
- INV_VEC, 31, micro-address taken on dispatch miss or ACTRL=111.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  OPC_WIDTH  instruction opcode.
- funct  in  FUNCT_WIDTH  instruction funct.
- of  in  1  ALU overflow.
- stall  in  1  freeze sequencer.
- wait_cond  in  1  condition for WAIT states.
- cs_we  in  1  control store write strobe.
- cs_waddr  in  ADDR_WIDTH  control store write address.
- cs_wdata  in  CW_WIDTH  control store write data.
- dt_we  in  1  dispatch CAM write strobe.
- dt_waddr  in  clog2(DT_ENTRIES)  CAM entry index.
- dt_wdata  in  4+OPC_WIDTH+FUNCT_WIDTH+ADDR_WIDTH  {valid, tbl[1:0], fmask, opcode, funct, target}.
- cw  out  CW_WIDTH  current control word.
- current_state  out  ADDR_WIDTH  current micro-address (upc).
- exc_taken  out  1  one-cycle pulse: overflow vector taken.
- invalid_op  out  1  one-cycle pulse: invalid vector taken.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- State registers: upc, control store cs, dispatch CAM, exc_taken, invalid_op.
- Control word read: cw = cs[upc], asynchronous read. current_state = upc.
- Reset effect:
  - upc=0; exc_taken=0; invalid_op=0; all CAM valid bits cleared.
  - cs contents are retained across reset.
  - cw after reset = cs[0].
- Next-upc priority at each edge, highest first:
  1. reset.
  2. stall=1: upc held, pulses 0.
  3. of=1: upc=EXC_VEC, exc_taken=1.
  4. ACTRL decode, where ACTRL = cs[upc][2:0]:
     - 000 FETCH: upc=0.
     - 001 SEQ: upc=upc+1, wrapping modulo 2**ADDR_WIDTH.
     - 010 / 011 / 100: dispatch through table 1 / 2 / 3.
     - 101 WAIT: hold while wait_cond=1, else upc+1.
     - 110 TRAP: upc=EXC_VEC, exc_taken=1.
     - 111 INVALID: upc=INV_VEC, invalid_op=1.
- Dispatch matching:
  - An entry matches when valid=1, tbl equals the selected table (1..3), opcode is equal, and (fmask=0 or funct is equal).
  - The lowest-index matching entry wins and supplies upc=target.
  - No match: upc=INV_VEC, invalid_op=1.
  - A tbl=0 entry never matches.
- Pulses: exc_taken and invalid_op are registered, high exactly the cycle upc first shows the vector, low otherwise.
- Control store write:
  - cs_we writes cs[cs_waddr] at the edge, allowed while running.
  - If cs_waddr==upc, cw shows old data this cycle and the new word from the next cycle.
  - The next-upc decode uses the old word.
- CAM write:
  - dt_we writes the entry at the edge; the new entry is used from the next cycle.
  - A simultaneous dispatch uses the old contents.
  - dt_we during reset: reset wins, all valid bits cleared.
- Latency: one cycle from ACTRL/dispatch decision to the new cw.
- Input sampling: opcode and funct are sampled only in dispatch states. of is ignored while stall=1.
- Reset mid-operation: the next cycle is upc=0 regardless of stall, of or pending writes.

Test Plan:
- Boot and FETCH:
  - Load cs[0]=ACTRL 001 and cs[1]=ACTRL 010.
  - Load CAM[0]={1,01,0,000000,-,01100} and CAM[1]={1,01,1,000000,100000,01101}.
  - Apply reset, then opcode=0, funct=32.
  - Expect upc sequence 0,1,12. CAM[1] must not win over CAM[0].
- Funct-qualified dispatch:
  - Invalidate CAM[0].
  - Expect the same program to go 0,1,13.
  - With funct=24, expect upc=31 with invalid_op pulsed for 1 cycle.
- Overflow:
  - At upc=12 (ACTRL 001), raise of for one cycle.
  - Expect upc=30 and exc_taken=1 for 1 cycle.
  - Repeat with stall=1: expect upc held at 12 and no pulse.
- WAIT and stall:
  - Set cs[5]=ACTRL 101 and hold wait_cond=1 for 3 cycles.
  - Expect upc=5 for 3 cycles, then 6.
  - Assert stall for 2 cycles during SEQ: expect upc frozen for 2 cycles.
- Live write and wrap:
  - Write cs[upc] while executing: expect cw to update the next cycle only.
  - Execute ACTRL 001 at upc=31: expect wrap to 0.
- Reset mid-dispatch:
  - Assert reset with stall=1, of=1 and dt_we=1.
  - Expect upc=0, pulses 0, all CAM entries invalid, cs unchanged.
